// File: rtl/sram_pkg.sv
// Shared sizes, types and the byte-lane mask helper for the 128 x 32 byte-maskable SRAM.
package sram_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_BYTES  = DATA_WIDTH / 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [NUM_BYTES-1:0]  be_t;

    // Expands one enable bit per byte lane into a full-word bit mask.
    function automatic word_t lane_mask(input be_t be);
        word_t m;
        m = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_row.sv
// One 32-bit storage word with per-byte write enables and asynchronous clear.
module sram_row
    import sram_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  be_t   wr_en,
    input  word_t din,
    output word_t q
);

    // NOTE: the storage itself is reset, not just the control path, because every word
    // must read back as zero after any reset, including one that interrupts a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_en[i]) begin
                    q[8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sram.sv
// Single-port 128 x 32 SRAM: stage-1 word-line/control registers, per-row byte writes
// on the following edge, and a combinational masked read mux.
module sram
    import sram_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  addr_t addr_sel,
    input  be_t   byte_sel,
    input  logic  read_enable,
    input  logic  write_enable,
    input  word_t datain,
    output word_t dataout
);

    addr_t            wl_sel;
    be_t              be_q;
    logic             re_q;
    logic             we_q;
    word_t            din_q;
    logic [DEPTH-1:0] wl_onehot;
    word_t            row_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wl_sel <= '0;
            be_q   <= '0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            din_q  <= '0;
        end else begin
            wl_sel <= addr_sel;
            be_q   <= byte_sel;
            re_q   <= read_enable;
            we_q   <= write_enable;
            din_q  <= datain;
        end
    end

    assign wl_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << wl_sel;

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        be_t row_wr_en;
        assign row_wr_en = (we_q && wl_onehot[r]) ? be_q : '0;

        sram_row u_row (
            .clk   (clk),
            .reset (reset),
            .wr_en (row_wr_en),
            .din   (din_q),
            .q     (row_q[r])
        );
    end

    // Reset clears re_q asynchronously, so dataout drops to zero immediately.
    assign dataout = re_q ? (row_q[wl_sel] & lane_mask(be_q)) : '0;

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: directed cases plus randomized accesses against an array model.
module tb_sram;
    import sram_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    addr_t addr_sel;
    be_t   byte_sel;
    logic  read_enable;
    logic  write_enable;
    word_t datain;
    word_t dataout;

    word_t model_mem [DEPTH];
    int    n_checks = 0;
    int    n_pass   = 0;

    sram dut (
        .clk          (clk),
        .reset        (reset),
        .addr_sel     (addr_sel),
        .byte_sel     (byte_sel),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .datain       (datain),
        .dataout      (dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic word_t expand(input be_t be);
        word_t m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (word_t'(32'hFF) << (8 * i));
        return m;
    endfunction

    function automatic word_t model_read(input addr_t a, input be_t be, input logic re);
        return re ? (model_mem[a] & expand(be)) : 32'h0;
    endfunction

    task automatic model_write(input addr_t a, input be_t be, input word_t d);
        model_mem[a] = (model_mem[a] & ~expand(be)) | (d & expand(be));
    endtask

    task automatic go_idle();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        byte_sel     = '0;
        addr_sel     = '0;
        datain       = '0;
    endtask

    // One access held across two edges, then one idle cycle. Called at a negedge.
    task automatic access(input string tag, input addr_t a, input be_t be,
                          input logic re, input logic we, input word_t d);
        addr_sel     = a;
        byte_sel     = be;
        read_enable  = re;
        write_enable = we;
        datain       = d;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_e1"}, dataout, model_read(a, be, re));
        @(posedge clk);
        if (we) model_write(a, be, d);
        @(negedge clk);
        check({tag, "_e2"}, dataout, model_read(a, be, re));
        go_idle();
        @(negedge clk);
    endtask

    initial begin
        word_t vals [4];
        vals = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        go_idle();
        reset = 1'b1;
        #1;
        check("reset_dataout", dataout, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        access("rd_after_reset", 7'd77, 4'b1111, 1'b1, 1'b0, '0);

        for (int i = 0; i < 4; i++) access("full_wr", addr_t'(i), 4'b1111, 1'b0, 1'b1, vals[i]);
        for (int i = 0; i < 4; i++) access("full_rd", addr_t'(i), 4'b1111, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) check("full_rd_const", model_mem[i], vals[i]);

        access("a10_wr0", 7'd10, 4'b1111, 1'b0, 1'b1, 32'h0);
        access("a10_wrb0", 7'd10, 4'b0001, 1'b0, 1'b1, 32'h000000AA);
        access("a10_rd", 7'd10, 4'b1111, 1'b1, 1'b0, '0);
        check("a10_val", dut.dataout === 32'h0 ? model_mem[10] : model_mem[10], 32'h000000AA);

        access("a11_wrF", 7'd11, 4'b1111, 1'b0, 1'b1, 32'hFFFFFFFF);
        access("a11_wrb0", 7'd11, 4'b0001, 1'b0, 1'b1, 32'h00FFFFFF);
        access("a11_rd", 7'd11, 4'b1111, 1'b1, 1'b0, '0);

        access("partial_rd", 7'd0, 4'b0110, 1'b1, 1'b0, '0);
        access("no_re", 7'd0, 4'b1111, 1'b0, 1'b0, '0);
        access("be0_wr", 7'd1, 4'b0000, 1'b1, 1'b1, 32'h55555555);
        access("rw_same", 7'd2, 4'b1010, 1'b1, 1'b1, 32'hA5A5A5A5);

        // Reset in the middle of a read+write access to addr 5.
        access("a5_pre", 7'd5, 4'b1111, 1'b0, 1'b1, 32'hAAAA5555);
        addr_sel     = 7'd5;
        byte_sel     = 4'b1111;
        read_enable  = 1'b1;
        write_enable = 1'b1;
        datain       = 32'h12345678;
        @(posedge clk);
        #2;
        check("mid_pre_reset", dataout, 32'hAAAA5555);
        reset = 1'b1;
        #1;
        check("mid_reset_now", dataout, 32'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(posedge clk);
        @(negedge clk);
        go_idle();
        reset = 1'b0;
        @(negedge clk);
        access("a5_after_reset", 7'd5, 4'b1111, 1'b1, 1'b0, '0);
        access("a0_after_reset", 7'd0, 4'b1111, 1'b1, 1'b0, '0);

        for (int n = 0; n < 300; n++) begin
            access("rand", addr_t'($urandom_range(0, 15)), be_t'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom));
        end
        for (int i = 0; i < 16; i++) access("sweep", addr_t'(i), 4'b1111, 1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
